// File: rtl/poker_video_pkg.sv
// Shared video types and constants for the poker display pipeline.
package poker_video_pkg;

    typedef enum logic [1:0] {
        BLACK,
        FADING_IN,
        SHOWN,
        FADING_OUT
    } fade_state_t;

    localparam logic [4:0] LEVEL_MAX = 5'd16;

    typedef logic [3:0] rgb4_t;

endpackage

// File: rtl/rgb_scale.sv
// Combinational brightness scaler for one 4-bit colour channel: (color * level) >> 4.
module rgb_scale
    import poker_video_pkg::*;
(
    input  logic [3:0] color,
    input  logic [4:0] level,
    output logic [3:0] scaled
);

    logic [7:0] product;

    // Level 16 shifts back to the exact input; the largest product is 15*16 = 240.
    assign product = {4'b0000, color} * {3'b000, level};
    assign scaled  = product[7:4];

endmodule

// File: rtl/screen_fader.sv
// Scales the RGB stream by a frame-stable level and ramps that level on fade commands.
module screen_fader
    import poker_video_pkg::*;
#(
    parameter int unsigned STEP_FRAMES = 2
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       vde_in,
    input  logic       fade_in_start,
    input  logic       fade_out_start,
    output logic [3:0] red_out,
    output logic [3:0] green_out,
    output logic [3:0] blue_out,
    output logic       hs_out,
    output logic       vs_out,
    output logic       vde_out,
    output logic [4:0] level,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] LAST_FRAME = 8'(STEP_FRAMES - 1);

    fade_state_t state;
    logic [7:0]  frame_cnt;
    logic        vs_prev;
    logic        frame_tick;
    logic        accept_out;
    logic        accept_in;
    rgb4_t       red_scaled;
    rgb4_t       green_scaled;
    rgb4_t       blue_scaled;

    // Frame boundary is the falling edge of the active-low vertical sync.
    assign frame_tick = vs_prev & ~vs_in;
    assign accept_out = fade_out_start && (state == SHOWN || state == FADING_IN);
    assign accept_in  = fade_in_start && (state == BLACK || state == FADING_OUT);

    rgb_scale u_scale_red   (.color(red_in),   .level(level), .scaled(red_scaled));
    rgb_scale u_scale_green (.color(green_in), .level(level), .scaled(green_scaled));
    rgb_scale u_scale_blue  (.color(blue_in),  .level(level), .scaled(blue_scaled));

    // NOTE: reset is synchronous, so it sits inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state     <= BLACK;
            level     <= 5'd0;
            frame_cnt <= 8'd0;
            vs_prev   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            vs_prev <= vs_in;
            done    <= 1'b0;
            if (accept_out) begin
                state     <= FADING_OUT;
                frame_cnt <= 8'd0;
                busy      <= 1'b1;
            end else if (accept_in) begin
                state     <= FADING_IN;
                frame_cnt <= 8'd0;
                busy      <= 1'b1;
            end else if (frame_tick && (state == FADING_IN || state == FADING_OUT)) begin
                if (frame_cnt == LAST_FRAME) begin
                    frame_cnt <= 8'd0;
                    // Saturating ends cover a reversal issued before the level has moved.
                    if (state == FADING_IN) begin
                        if (level >= LEVEL_MAX - 5'd1) begin
                            level <= LEVEL_MAX;
                            state <= SHOWN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            level <= level + 5'd1;
                        end
                    end else begin
                        if (level <= 5'd1) begin
                            level <= 5'd0;
                            state <= BLACK;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            level <= level - 5'd1;
                        end
                    end
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            red_out   <= 4'd0;
            green_out <= 4'd0;
            blue_out  <= 4'd0;
            hs_out    <= 1'b1;
            vs_out    <= 1'b1;
            vde_out   <= 1'b0;
        end else begin
            red_out   <= vde_in ? red_scaled   : 4'd0;
            green_out <= vde_in ? green_scaled : 4'd0;
            blue_out  <= vde_in ? blue_scaled  : 4'd0;
            hs_out    <= hs_in;
            vs_out    <= vs_in;
            vde_out   <= vde_in;
        end
    end

endmodule
